// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spart_pkg
//  Brief    : Shared SPART types and constants (transmit FSM states, default
//             oversampling ratio and frame length).
//  Revision : 1.0  initial release
// ============================================================================
package spart_pkg;

    // Transmit FSM states, encoded in the same style as the receiver FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // b_en ticks per bit period used by the baud block by default.
    localparam int c_OSR_DEFAULT       = 16;
    localparam int c_DATA_BITS_DEFAULT = 8;

    // One frame is a start bit, the data bits and a stop bit.
    localparam int c_FRAME_TICKS = (c_DATA_BITS_DEFAULT + 2) * c_OSR_DEFAULT;

    // Frame length in b_en ticks for an arbitrary configuration.
    function automatic int frame_ticks(input int osr, input int data_bits);
        return (data_bits + 2) * osr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spart_tx
//  Brief    : SPART transmitter. One-entry holding buffer written from the
//             processor bus, serialised as start / DATA_BITS data / stop on a
//             registered, high-idling serial line timed by the b_en strobe.
//  Revision : 1.0  initial release
// ============================================================================
module spart_tx
    import spart_pkg::*;
#(
    parameter int OSR       = c_OSR_DEFAULT,
    parameter int DATA_BITS = c_DATA_BITS_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_en,
    input  logic                 i_iocs,
    input  logic                 i_iorw,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tbr,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int                  c_TICK_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OSR - 1);
    localparam int                  c_BIT_W     = $clog2(DATA_BITS + 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_buf;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;

    logic                 w_wr_accept;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_first_bit;
    logic                 w_next_bit;

    // A write only lands when the holding buffer is empty; o_tbr is that flag.
    assign w_wr_accept = i_iocs & ~i_iorw & o_tbr;
    assign w_bit_end   = (r_tick_cnt == c_TICK_LAST);

    // Shift direction and bit pick-off follow the receiver's bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[DATA_BITS-2:0], 1'b0};
            assign w_first_bit  = r_shift[DATA_BITS-1];
            assign w_next_bit   = r_shift[DATA_BITS-2];
        end else begin : g_lsb_first
            assign w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
            assign w_first_bit  = r_shift[0];
            assign w_next_bit   = r_shift[1];
        end
    endgenerate

    // Holding buffer, frame FSM, bit timing and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_shift    <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            o_tbr      <= 1'b1;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
        end else begin
            // Write and transfer are mutually exclusive: a transfer needs
            // o_tbr low, an accepted write needs it high.
            if (w_wr_accept) begin
                r_buf <= i_data;
                o_tbr <= 1'b0;
            end
            if (b_en) begin
                case (r_state)
                    IDLE: begin
                        if (!o_tbr) begin
                            r_shift    <= r_buf;
                            o_tbr      <= 1'b1;
                            o_tx       <= 1'b0;
                            o_busy     <= 1'b1;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= START;
                        end
                    end
                    START: begin
                        if (w_bit_end) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            o_tx       <= w_first_bit;
                            r_state    <= DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_bit_end) begin
                            r_tick_cnt <= '0;
                            r_shift    <= w_shift_next;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_BIT_LAST) begin
                                o_tx    <= 1'b1;
                                r_state <= STOP;
                            end else begin
                                o_tx <= w_next_bit;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (w_bit_end) begin
                            r_tick_cnt <= '0;
                            if (!o_tbr) begin
                                // Pending byte: start the next frame with no idle gap.
                                r_shift   <= r_buf;
                                r_bit_cnt <= '0;
                                o_tbr     <= 1'b1;
                                o_tx      <= 1'b0;
                                r_state   <= START;
                            end else begin
                                o_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        o_tx    <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spart_tx
//  Brief    : Self-checking bench for spart_tx. Two instances (OSR=16 MSB
//             first, OSR=4 LSB first) share the bus; a frame-position model
//             predicts every output each cycle, and a mid-bit line decoder
//             recovers the transmitted bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spart_tx;

    typedef bit bitq_t[$];
    typedef int intq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_en = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b1;
    logic [7:0] data = 8'h00;
    logic       tbr0, tx0, busy0;
    logic       tbr1, tx1, busy1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    bit mon_en = 1'b0;
    bit ben_rand = 1'b0;

    spart_tx #(.OSR(16), .DATA_BITS(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .b_en(b_en), .i_iocs(iocs), .i_iorw(iorw),
        .i_data(data), .o_tbr(tbr0), .o_tx(tx0), .o_busy(busy0)
    );

    spart_tx #(.OSR(4), .DATA_BITS(8), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .b_en(b_en), .i_iocs(iocs), .i_iorw(iorw),
        .i_data(data), .o_tbr(tbr1), .o_tx(tx1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frame position per instance --------
    int         m_pos[2] = '{-1, -1};
    bit         m_bfull[2] = '{1'b0, 1'b0};
    logic [7:0] m_buf[2];
    logic [7:0] m_byte[2];
    int         m_sent0[$];
    int         m_sent1[$];

    function automatic int osr_of(input int n);
        return (n == 0) ? 16 : 4;
    endfunction

    function automatic void start_frame(input int n);
        m_byte[n]  = m_buf[n];
        m_bfull[n] = 1'b0;
        m_pos[n]   = 0;
        if (n == 0) m_sent0.push_back(int'(m_buf[n]));
        else        m_sent1.push_back(int'(m_buf[n]));
    endfunction

    // Line level implied by the position inside the current frame.
    function automatic int exp_tx(input int n);
        int b;
        if (m_pos[n] < 0) return 1;
        b = m_pos[n] / osr_of(n);
        if (b == 0) return 0;
        if (b >= 9) return 1;
        return (n == 0) ? int'(m_byte[n][8-b]) : int'(m_byte[n][b-1]);
    endfunction

    always @(posedge clk) begin
        bit old;
        for (int n = 0; n < 2; n++) begin
            if (!rst) begin
                m_pos[n]   = -1;
                m_bfull[n] = 1'b0;
            end else begin
                old = m_bfull[n];
                if (b_en) begin
                    if (m_pos[n] < 0) begin
                        if (old) start_frame(n);
                    end else begin
                        m_pos[n]++;
                        if (m_pos[n] == 10 * osr_of(n)) begin
                            if (old) start_frame(n);
                            else     m_pos[n] = -1;
                        end
                    end
                end
                if (iocs && !iorw && !old) begin
                    m_buf[n]   = data;
                    m_bfull[n] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx0",   int'(tx0),   exp_tx(0));
            chk("tbr0",  int'(tbr0),  int'(!m_bfull[0]));
            chk("busy0", int'(busy0), int'(m_pos[0] >= 0));
            chk("tx1",   int'(tx1),   exp_tx(1));
            chk("tbr1",  int'(tbr1),  int'(!m_bfull[1]));
            chk("busy1", int'(busy1), int'(m_pos[1] >= 0));
        end
    end

    // ---------------- line monitor: o_tx after every b_en tick ---------------
    bit q0[$];
    bit q1[$];

    always @(posedge clk) begin
        if (mon_en && b_en && rst) begin
            #1;
            q0.push_back(tx0);
            q1.push_back(tx1);
        end
    end

    task automatic clear_mon();
        q0 = {1'b1};
        q1 = {1'b1};
        m_sent0.delete();
        m_sent1.delete();
    endtask

    // UART-style decode: find a falling edge, sample each bit at its middle.
    task automatic decode(input bitq_t q, input int osr, input bit msb,
                          output intq_t bytes, output intq_t starts,
                          output intq_t pats, output int nbad);
        int i, v, p;
        bit b;
        bytes = {}; starts = {}; pats = {}; nbad = 0; i = 1;
        while (i + 10 * osr <= q.size()) begin
            if (q[i-1] == 1'b1 && q[i] == 1'b0) begin
                v = 0; p = 0;
                for (int k = 0; k < 10; k++) begin
                    b = q[i + osr/2 + k*osr];
                    p = (p << 1) | int'(b);
                    if (k >= 1 && k <= 8) begin
                        if (msb) v = (v << 1) | int'(b);
                        else     v = v | (int'(b) << (k - 1));
                    end
                end
                if (p[9] != 1'b0 || p[0] != 1'b1) nbad++;
                bytes.push_back(v); starts.push_back(i); pats.push_back(p);
                i += 10 * osr;
            end else begin
                i++;
            end
        end
    endtask

    // ---------------- stimulus drivers ---------------------------------------
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (ben_rand) b_en = ($urandom_range(0, 2) == 0);
            else begin
                b_en = (cnt == 0);
                cnt  = (cnt + 1) % 4;
            end
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic bus_write(input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; data = d;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(tbr0 && tbr1 && !busy0 && !busy1) && c < limit);
        chk("wait_idle_timeout", int'(c < limit), 1);
    endtask

    task automatic wait_tbr0(input int limit);
        int c;
        c = 0;
        while (!tbr0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("wait_tbr_timeout", int'(c < limit), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ------------------------------------------
    initial begin
        intq_t by0, st0, pt0, by1, st1, pt1;
        int nb0, nb1, zeros, c;

        // Reset then idle
        rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_tx", int'(tx0), 1);
        chk("reset_tbr", int'(tbr0), 1);
        chk("reset_busy", int'(busy0), 0);
        rst = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        repeat (800) @(negedge clk);
        zeros = 0;
        foreach (q0[k]) if (q0[k] == 1'b0) zeros++;
        chk("idle_line_zeros", zeros, 0);
        chk("idle_ticks_seen", int'(q0.size() >= 200), 1);

        // Single byte 0xA5
        clear_mon();
        bus_write(8'hA5);
        chk("tbr_low_after_write", int'(tbr0), 0);
        wait_idle(3000);
        decode(q0, 16, 1'b1, by0, st0, pt0, nb0);
        decode(q1, 4, 1'b0, by1, st1, pt1, nb1);
        chk("a5_frames0", by0.size(), 1);
        chk("a5_frames1", by1.size(), 1);
        if (by0.size() == 1) begin
            chk("a5_byte0", by0[0], 8'hA5);
            chk("a5_pattern0", pt0[0], 10'b0101001011);
        end
        if (by1.size() == 1) chk("a5_byte1", by1[0], 8'hA5);
        chk("a5_bad", nb0 + nb1, 0);

        // Back-to-back 0x3C then 0xC3
        clear_mon();
        bus_write(8'h3C);
        wait_tbr0(200);
        bus_write(8'hC3);
        wait_idle(5000);
        decode(q0, 16, 1'b1, by0, st0, pt0, nb0);
        decode(q1, 4, 1'b0, by1, st1, pt1, nb1);
        chk("b2b_frames0", by0.size(), 2);
        chk("b2b_frames1", by1.size(), 2);
        if (by0.size() == 2) begin
            chk("b2b_byte0a", by0[0], 8'h3C);
            chk("b2b_byte0b", by0[1], 8'hC3);
            chk("b2b_gap0", st0[1] - st0[0], 160);
        end
        if (by1.size() == 2) begin
            chk("b2b_byte1b", by1[1], 8'hC3);
            chk("b2b_gap1", st1[1] - st1[0], 40);
        end

        // Overrun: third byte dropped
        clear_mon();
        bus_write(8'h11);
        wait_tbr0(200);
        bus_write(8'h22);
        bus_write(8'h33);
        wait_idle(5000);
        decode(q0, 16, 1'b1, by0, st0, pt0, nb0);
        decode(q1, 4, 1'b0, by1, st1, pt1, nb1);
        chk("ovr_frames0", by0.size(), 2);
        chk("ovr_frames1", by1.size(), 2);
        if (by0.size() == 2) begin
            chk("ovr_byte0a", by0[0], 8'h11);
            chk("ovr_byte0b", by0[1], 8'h22);
        end

        // Reset mid-frame at data bit 3 of 0x00
        clear_mon();
        bus_write(8'h00);
        c = 0;
        while (tx0 !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("mid_fall_timeout", int'(c < 200), 1);
        c = 0;
        while (c < 72) begin
            @(posedge clk);
            if (b_en) c++;
        end
        @(negedge clk);
        chk("mid_busy_before", int'(busy0), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_tx", int'(tx0), 1);
        chk("mid_reset_tbr", int'(tbr0), 1);
        chk("mid_reset_busy", int'(busy0), 0);
        rst = 1'b1;
        clear_mon();
        bus_write(8'hFF);
        wait_idle(3000);
        decode(q0, 16, 1'b1, by0, st0, pt0, nb0);
        chk("mid_frames0", by0.size(), 1);
        if (by0.size() == 1) begin
            chk("mid_byte0", by0[0], 8'hFF);
            chk("mid_pattern0", pt0[0], 10'b0111111111);
        end

        // LSB-first order with 0x01
        clear_mon();
        bus_write(8'h01);
        wait_idle(3000);
        decode(q0, 16, 1'b1, by0, st0, pt0, nb0);
        decode(q1, 4, 1'b0, by1, st1, pt1, nb1);
        chk("lsb_frames1", by1.size(), 1);
        if (by1.size() == 1) begin
            chk("lsb_byte1", by1[0], 8'h01);
            chk("lsb_pattern1", pt1[0], 10'b0100000001);
        end
        if (by0.size() == 1) chk("msb_pattern0_01", pt0[0], 10'b0000000011);

        // Randomized traffic and b_en pattern
        ben_rand = 1'b1;
        clear_mon();
        for (int i = 0; i < 6000; i++) begin
            iocs = ($urandom_range(0, 9) == 0);
            iorw = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            @(negedge clk);
        end
        iocs = 1'b0; iorw = 1'b1;
        wait_idle(8000);
        decode(q0, 16, 1'b1, by0, st0, pt0, nb0);
        decode(q1, 4, 1'b0, by1, st1, pt1, nb1);
        chk("rnd_frames0", by0.size(), m_sent0.size());
        chk("rnd_frames1", by1.size(), m_sent1.size());
        chk("rnd_bad", nb0 + nb1, 0);
        for (int k = 0; k < by0.size() && k < m_sent0.size(); k++)
            chk("rnd_byte0", by0[k], m_sent0[k]);
        for (int k = 0; k < by1.size() && k < m_sent1.size(); k++)
            chk("rnd_byte1", by1[k], m_sent1[k]);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spart_tx.md
Name: spart_tx

Overview:
Transmit half of the SPART. It accepts a byte from the processor bus through a one-entry holding buffer, then serialises it on o_tx as an asynchronous frame: 1 start bit (0), DATA_BITS data bits, 1 stop bit (1). Bit timing comes from the shared baud-enable strobe b_en, which runs at OSR ticks per bit. Bit order matches the SPART receiver, so the two blocks loop back directly.

Parameters:
OSR, 16, b_en ticks per bit period (power of 2, 2..256)
DATA_BITS, 8, data bits per frame
MSB_FIRST, 1, 1 = bit [DATA_BITS-1] transmitted first (matches receiver shift-in); 0 = LSB first

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
b_en  input  1  baud enable strobe, one clk wide, OSR strobes per bit
i_iocs  input  1  SPART chip select
i_iorw  input  1  1 = read, 0 = write
i_data  input  DATA_BITS  write data from processor
o_tbr  output  1  transmit buffer ready (holding buffer empty, write accepted)
o_tx  output  1  serial line, registered, idles high
o_busy  output  1  shifter active (state != IDLE)

Behaviour:
- Reset (rst==0 at posedge clk): o_tx=1, o_tbr=1, o_busy=0, state=IDLE, holding buffer empty, shifter/counters cleared. Reset mid-frame aborts the frame immediately; o_tx returns high the next cycle.
- Write accept: i_iocs && !i_iorw && o_tbr at posedge clk, independent of b_en. Captures i_data into the holding buffer; o_tbr=0 from the next cycle.
- Ignored writes: a write with o_tbr==0 is dropped. No overwrite and no error flag. Reads (i_iorw=1) have no effect.
- States: IDLE, START, DATA, STOP. All transitions and counter updates occur only on cycles with b_en=1.
- IDLE: on b_en, if the buffer is full: move the buffer to the shifter, set o_tbr=1 on the next cycle, drive o_tx=0, go to START. tick_cnt=0, bit_cnt=0.
- tick_cnt counts 0..OSR-1 on b_en. Reaching OSR-1 ends the current bit period and wraps tick_cnt to 0.
- START: o_tx=0 for OSR ticks. At the end, o_tx = first data bit and the state goes to DATA.
- DATA: each bit lasts OSR ticks. At each bit end, the shifter shifts (direction set by MSB_FIRST) and bit_cnt increments. After bit DATA_BITS-1, o_tx=1 and the state goes to STOP.
- STOP: o_tx=1 for OSR ticks. At the end:
  - if the buffer is full, go directly to START (o_tx=0, reload the shifter, o_tbr=1), giving back-to-back frames with no idle gap;
  - otherwise go to IDLE.
- Frame length: (DATA_BITS+2)*OSR b_en ticks; 160 at the defaults.
- Latency: a write accepted while IDLE produces the start bit at the first b_en that is at least 1 cycle after the write (the buffer is registered).
- Simultaneous events:
  - A write in the same cycle as a buffer→shifter transfer is dropped, because o_tbr is still 0 that cycle.
  - A write during a frame fills the buffer. o_tbr then stays 0 until that byte moves to the shifter at STOP end.
- o_tx changes only on b_en cycles (glitch-free, registered). o_busy = (state != IDLE), registered.
- Width rules: tick_cnt is $clog2(OSR) bits. bit_cnt is $clog2(DATA_BITS+1) bits. No arithmetic overflow beyond the defined wraps.

Decomposition:
- spart_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, STOP}, shared in style with the receiver FSM;
  - OSR default;
  - frame-length constant.
- No sub-module; a single FSM plus datapath. The b_en generator lives in the existing SPART baud block.

Test Plan:
- Reset then idle: hold rst=0 for 3 clk, release, run 200 b_en -> o_tx=1, o_tbr=1, o_busy=0 throughout.
- Single byte 0xA5, MSB_FIRST=1, b_en every 4 clk -> o_tx sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1; each bit lasts 16 b_en; o_tbr low 1 cycle after the write, high again 1 cycle after entering START.
- Back-to-back: write 0x3C, then write 0xC3 when o_tbr reasserts -> two contiguous 160-tick frames with no idle tick between the stop and start bits; a looped-back receiver yields o_data 0x3C then 0xC3.
- Overrun: write 0x11, 0x22, 0x33 on consecutive enabled cycles -> 0x11 sent, 0x22 sent, 0x33 dropped; exactly 2 frames on the line.
- Reset mid-frame: assert rst at DATA bit 3 of 0x00 -> o_tx=1 next cycle, o_tbr=1, a following write of 0xFF produces a clean full frame.
- MSB_FIRST=0 with 0x01 -> data bits on the line are 1,0,0,0,0,0,0,0.
